// File: rtl/gb80_pkg.sv
// rtl/gb80_pkg.sv - shared GB80 ALU control codes, sequencer op codes, flag bit indices and sequencer states
package gb80_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_ADC = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_SBC = 3'd3;

  localparam logic [1:0] SEQ_ADD16     = 2'd0;
  localparam logic [1:0] SEQ_INC16     = 2'd1;
  localparam logic [1:0] SEQ_DEC16     = 2'd2;
  localparam logic [1:0] SEQ_ADD_SP_E8 = 2'd3;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu16_sequencer_if.sv
// rtl/alu16_sequencer_if.sv - shared 8-bit ALU bus; master = sequencer, slave = ALU
interface alu16_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
);

  logic                    alu_req;
  logic [DATA_WIDTH-1:0]   alu_data_A;
  logic [DATA_WIDTH-1:0]   alu_data_B;
  logic [OPCODE_WIDTH-1:0] alu_control;
  logic                    alu_carry_in;
  logic [DATA_WIDTH-1:0]   alu_data;
  logic [7:0]              alu_flags;

  modport master (
    output alu_req, alu_data_A, alu_data_B, alu_control, alu_carry_in,
    input  alu_data, alu_flags
  );

  modport slave (
    input  alu_req, alu_data_A, alu_data_B, alu_control, alu_carry_in,
    output alu_data, alu_flags
  );

endinterface

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - two-pass 16-bit op sequencer over the shared 8-bit ALU
// ALU16_FAST_INCDEC_EN: INC16/DEC16 bypass the ALU through a direct 16-bit inc/dec (IDLE -> DONE).
module alu16_sequencer
  import gb80_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [1:0]              i_op,
  input  logic [2*DATA_WIDTH-1:0] i_operand_A,
  input  logic [2*DATA_WIDTH-1:0] i_operand_B,
  input  logic [7:0]              i_flags,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2*DATA_WIDTH-1:0] o_result,
  output logic [7:0]              o_flags,
  alu16_sequencer_if.master       alu
);

  localparam int W = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] BYTE_ONE = DATA_WIDTH'(1);

  seq_state_t            state;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] a_hi_q;
  logic [DATA_WIDTH-1:0] b_hi_q;
  logic [7:0]            f_q;
  logic [DATA_WIDTH-1:0] res_lo;
  logic                  lo_c;
  logic                  lo_h;
  logic [DATA_WIDTH-1:0] hi_b;
  logic [7:0]            new_flags;
  logic                  unused_alu_flags;

  assign unused_alu_flags = ^{alu.alu_flags[7:6], alu.alu_flags[3:0]};

  // High-byte addend is resolved at start so only one byte of B needs latching.
  always_comb begin
    hi_b = '0;
    case (i_op)
      SEQ_ADD16:     hi_b = i_operand_B[W-1:DATA_WIDTH];
      SEQ_ADD_SP_E8: hi_b = {DATA_WIDTH{i_operand_B[DATA_WIDTH-1]}};
      default:       hi_b = '0;
    endcase
  end

  always_comb begin
    new_flags = 8'h00;
    case (op_q)
      SEQ_ADD16: begin
        new_flags[FLAG_Z] = f_q[FLAG_Z];
        new_flags[FLAG_H] = alu.alu_flags[FLAG_H];
        new_flags[FLAG_C] = alu.alu_flags[FLAG_C];
      end
      SEQ_ADD_SP_E8: begin
        new_flags[FLAG_H] = lo_h;
        new_flags[FLAG_C] = lo_c;
      end
      default: new_flags = f_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      op_q             <= SEQ_ADD16;
      a_hi_q           <= '0;
      b_hi_q           <= '0;
      f_q              <= '0;
      res_lo           <= '0;
      lo_c             <= 1'b0;
      lo_h             <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_result         <= '0;
      o_flags          <= '0;
      alu.alu_req      <= 1'b0;
      alu.alu_data_A   <= '0;
      alu.alu_data_B   <= '0;
      alu.alu_control  <= '0;
      alu.alu_carry_in <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            op_q   <= i_op;
            a_hi_q <= i_operand_A[W-1:DATA_WIDTH];
            b_hi_q <= hi_b;
            f_q    <= i_flags;
            o_busy <= 1'b1;
`ifdef ALU16_FAST_INCDEC_EN
            if (i_op == SEQ_INC16 || i_op == SEQ_DEC16) begin
              o_result <= (i_op == SEQ_INC16) ? i_operand_A + W'(1) : i_operand_A - W'(1);
              o_flags  <= i_flags;
              o_done   <= 1'b1;
              state    <= ST_DONE;
            end else
`endif
            begin
              state            <= ST_LOW;
              alu.alu_req      <= 1'b1;
              alu.alu_data_A   <= i_operand_A[DATA_WIDTH-1:0];
              alu.alu_data_B   <= (i_op == SEQ_INC16 || i_op == SEQ_DEC16) ?
                                  BYTE_ONE : i_operand_B[DATA_WIDTH-1:0];
              alu.alu_control  <= (i_op == SEQ_DEC16) ? OPCODE_WIDTH'(ALU_SUB)
                                                       : OPCODE_WIDTH'(ALU_ADD);
              alu.alu_carry_in <= 1'b0;
            end
          end
        end
        ST_LOW: begin
          res_lo           <= alu.alu_data;
          lo_c             <= alu.alu_flags[FLAG_C];
          lo_h             <= alu.alu_flags[FLAG_H];
          state            <= ST_HIGH;
          alu.alu_data_A   <= a_hi_q;
          alu.alu_data_B   <= b_hi_q;
          alu.alu_control  <= (op_q == SEQ_DEC16) ? OPCODE_WIDTH'(ALU_SBC)
                                                   : OPCODE_WIDTH'(ALU_ADC);
          alu.alu_carry_in <= alu.alu_flags[FLAG_C];
        end
        ST_HIGH: begin
          o_result         <= {alu.alu_data, res_lo};
          o_flags          <= new_flags;
          o_done           <= 1'b1;
          state            <= ST_DONE;
          alu.alu_req      <= 1'b0;
          alu.alu_data_A   <= '0;
          alu.alu_data_B   <= '0;
          alu.alu_control  <= '0;
          alu.alu_carry_in <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
